// File: rtl/hist_pkg.sv
// Shared constants and FSM encoding for the histogram accumulator slice.
package hist_pkg;

  localparam int NBINS     = 256;
  localparam int AW        = 8;
  localparam int CW        = 16;
  // Bin that corresponds to zero delay; the distributer uses the same value.
  localparam int ADDRESS_0 = 128;

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_INC_RD = 3'd2,
    S_INC_WR = 3'd3,
    S_RD_RD  = 3'd4,
    S_RD_OUT = 3'd5
  } hist_state_t;

endpackage

// File: rtl/hist_dpram.sv
// Simple dual-port histogram RAM: one write port, one registered read port.
module hist_dpram #(
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] q
);

  logic [CW-1:0] mem [0:(1<<AW)-1];

  // Write port; contents are never reset, the controller sweeps zeros instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; q holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/histogram_accumulator.sv
// Histogram accumulator: edge-triggered read-modify-write +1 on a bin RAM,
// host read-out port, clear sweep and a count of increments lost while busy.
module histogram_accumulator
  import hist_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] Addr,
  input  logic          Memory_add,
  input  logic          clear,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [CW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic [15:0]   drop_count
);

  localparam logic [AW-1:0] LAST_BIN = AW'(NBINS - 1);

  hist_state_t   state, state_nxt;
  logic [AW-1:0] sweep_ptr;
  logic          madd_q;
  logic          inc_edge;
  logic          pend;
  logic          clr_pend;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] inc_addr;
  logic          take_clr, take_inc, take_rd;
  logic [1:0]    drop_n;

  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [CW-1:0] ram_wdata, ram_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // A freshly captured edge blocks a host read for one cycle so the
  // increment is always serviced before a read that arrives with it.
  assign inc_edge = Memory_add & ~madd_q;
  assign take_clr = (state == S_IDLE) && (clear || clr_pend);
  assign take_inc = (state == S_IDLE) && !take_clr && pend;
  assign take_rd  = (state == S_IDLE) && !take_clr && !pend && !inc_edge && rd_req;
  assign drop_n   = {1'b0, inc_edge && ((state == S_CLEAR) || take_clr)}
                  + {1'b0, take_clr && pend};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:  if (sweep_ptr == LAST_BIN) state_nxt = S_IDLE;
      S_IDLE: begin
        if (take_clr)      state_nxt = S_CLEAR;
        else if (take_inc) state_nxt = S_INC_RD;
        else if (take_rd)  state_nxt = S_RD_RD;
      end
      S_INC_RD: state_nxt = S_INC_WR;
      S_INC_WR: state_nxt = S_IDLE;
      S_RD_RD:  state_nxt = S_RD_OUT;
      S_RD_OUT: state_nxt = S_IDLE;
      default:  state_nxt = S_CLEAR;
    endcase
  end

  // FSM outputs: RAM port controls and busy flag.
  always_comb begin
    busy      = (state == S_CLEAR);
    ram_we    = 1'b0;
    ram_waddr = inc_addr;
    ram_wdata = sat_inc(ram_q);
    ram_re    = (state == S_IDLE);
    ram_raddr = pend ? pend_addr : rd_addr;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_ptr;
      ram_wdata = '0;
    end else if (state == S_INC_WR) begin
      ram_we    = 1'b1;
    end
  end

  // Control state: sweep pointer, edge register, pending flags, drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_ptr  <= '0;
      madd_q     <= 1'b0;
      pend       <= 1'b0;
      clr_pend   <= 1'b0;
      drop_count <= '0;
    end else begin
      madd_q <= Memory_add;
      if (take_clr)                 sweep_ptr <= '0;
      else if (state == S_CLEAR)    sweep_ptr <= sweep_ptr + AW'(1);
      if (inc_edge && (state != S_CLEAR) && !take_clr) pend <= 1'b1;
      else if (take_inc || take_clr)                   pend <= 1'b0;
      if (take_clr)                                    clr_pend <= 1'b0;
      else if (clear && (state != S_IDLE))             clr_pend <= 1'b1;
      drop_count <= sat_add16(drop_count, drop_n);
    end
  end

  // Captured bin addresses; pend_addr may be refilled while inc_addr is in use.
  always_ff @(posedge clk) begin
    if (inc_edge && (state != S_CLEAR)) pend_addr <= Addr;
    if (take_inc)                       inc_addr  <= pend_addr;
  end

  // Host read result: loaded while the RAM output is valid, strobed for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (state == S_RD_RD);
      if (state == S_RD_RD) rd_data <= ram_q;
    end
  end

  hist_dpram #(.AW(AW), .CW(CW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .q     (ram_q)
  );

endmodule
